// File: rtl/text_write_ctrl_if.sv
// Host character handshake and screen/colour RAM write bus
// for the text-mode write controller.
interface text_write_ctrl_if;
  logic        char_valid_i;
  logic [7:0]  char_data_i;
  logic [7:0]  colr_i;
  logic        char_ready_o;
  logic [11:0] wr_addr_o;
  logic [7:0]  wr_char_o;
  logic [7:0]  wr_colr_o;
  logic        wren_ms_o;
  logic        wren_mc_o;

  modport master (
    output char_valid_i,
    output char_data_i,
    output colr_i,
    input  char_ready_o,
    input  wr_addr_o,
    input  wr_char_o,
    input  wr_colr_o,
    input  wren_ms_o,
    input  wren_mc_o
  );

  modport slave (
    input  char_valid_i,
    input  char_data_i,
    input  colr_i,
    output char_ready_o,
    output wr_addr_o,
    output wr_char_o,
    output wr_colr_o,
    output wren_ms_o,
    output wren_mc_o
  );
endinterface

// File: rtl/text_write_ctrl.sv
// Text-mode write controller: places host characters into screen
// and colour RAMs, handles CR/LF/BS/FF and full-screen clears.
module text_write_ctrl #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter bit         CLR_ON_RST = 1'b1,
  parameter logic [7:0] RST_COLR   = 8'h07
) (
  input  logic              clk,
  input  logic              rst_n,
  text_write_ctrl_if.slave  bus,
  output logic [6:0]        cursor_x_o,
  output logic [4:0]        cursor_y_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } state_t;

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam logic [7:0] SPC  = 8'h20;

  state_t      state_q;
  logic        init_q;
  logic        ready_q;
  logic        busy_q;
  logic        wren_q;
  logic        last_q;
  logic [6:0]  cx_q;
  logic [4:0]  cy_q;
  logic [6:0]  clx_q;
  logic [4:0]  cly_q;
  logic [11:0] addr_q;
  logic [7:0]  char_q;
  logic [7:0]  colr_q;
  logic [7:0]  clcol_q;

  logic [6:0]  nx_d;
  logic [4:0]  ny_d;
  logic [4:0]  lfy_d;
  logic        acc;
  logic        is_bs;
  logic        is_lf;
  logic        is_ff;
  logic        is_cr;

  assign lfy_d = (cy_q == YMAX) ? 5'd0 : cy_q + 5'd1;
  assign nx_d  = (cx_q == XMAX) ? 7'd0 : cx_q + 7'd1;
  assign ny_d  = (cx_q == XMAX) ? lfy_d : cy_q;

  assign acc   = bus.char_valid_i & ready_q;
  assign is_bs = bus.char_data_i == 8'h08;
  assign is_lf = bus.char_data_i == 8'h0A;
  assign is_ff = bus.char_data_i == 8'h0C;
  assign is_cr = bus.char_data_i == 8'h0D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wren_q  <= 1'b0;
      last_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      clx_q   <= '0;
      cly_q   <= '0;
      addr_q  <= '0;
      char_q  <= '0;
      colr_q  <= '0;
      clcol_q <= '0;
    end else begin
      wren_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (init_q) begin
            init_q <= 1'b0;
            if (CLR_ON_RST) begin
              state_q <= CLEAR;
              busy_q  <= 1'b1;
              clcol_q <= RST_COLR;
              clx_q   <= '0;
              cly_q   <= '0;
              last_q  <= 1'b0;
            end else begin
              ready_q <= 1'b1;
            end
          end else if (acc) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WRITE;
            unique case (1'b1)
              is_ff: begin
                state_q <= CLEAR;
                clcol_q <= bus.colr_i;
                clx_q   <= '0;
                cly_q   <= '0;
                last_q  <= 1'b0;
              end
              is_cr: cx_q <= '0;
              is_lf: begin
                cx_q <= '0;
                cy_q <= lfy_d;
              end
              is_bs: begin
                // Backspace at column 0 is a silent no-op.
                if (cx_q != 7'd0) begin
                  cx_q   <= cx_q - 7'd1;
                  addr_q <= {cy_q, 7'(cx_q - 7'd1)};
                  char_q <= SPC;
                  colr_q <= bus.colr_i;
                  wren_q <= 1'b1;
                end
              end
              default: begin
                addr_q <= {cy_q, cx_q};
                char_q <= bus.char_data_i;
                colr_q <= bus.colr_i;
                wren_q <= 1'b1;
                cx_q   <= nx_d;
                cy_q   <= ny_d;
              end
            endcase
          end
        end
        WRITE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        CLEAR: begin
          if (last_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
          end else begin
            wren_q <= 1'b1;
            addr_q <= {cly_q, clx_q};
            char_q <= SPC;
            colr_q <= clcol_q;
            if (clx_q == XMAX) begin
              clx_q <= '0;
              if (cly_q == YMAX) last_q <= 1'b1;
              else               cly_q  <= cly_q + 5'd1;
            end else begin
              clx_q <= clx_q + 7'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.char_ready_o = ready_q;
  assign bus.wr_addr_o    = addr_q;
  assign bus.wr_char_o    = char_q;
  assign bus.wr_colr_o    = colr_q;
  assign bus.wren_ms_o    = wren_q;
  assign bus.wren_mc_o    = wren_q;
  assign cursor_x_o       = cx_q;
  assign cursor_y_o       = cy_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Directed bench for text_write_ctrl: reset clear, printable writes,
// wrap, control codes, throughput and reset abort of a clear.
module tb_text_write_ctrl;
  logic clk;
  logic rst_n;
  logic [6:0] cx, cx1;
  logic [4:0] cy, cy1;
  logic busy, busy1;

  text_write_ctrl_if bus ();
  text_write_ctrl_if bus1 ();

  text_write_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .cursor_x_o (cx),
    .cursor_y_o (cy),
    .busy_o     (busy)
  );

  text_write_ctrl #(.CLR_ON_RST(1'b0)) u_nc (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus1.slave),
    .cursor_x_o (cx1),
    .cursor_y_o (cy1),
    .busy_o     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int en_mis  = 0;
  logic [27:0] wlog[$];

  always @(posedge clk) begin
    if (bus.wren_ms_o != bus.wren_mc_o) en_mis++;
    if (bus.wren_ms_o)
      wlog.push_back({bus.wr_addr_o, bus.wr_char_o, bus.wr_colr_o});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!bus.char_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.char_ready_o) chk("wait_rdy", 32'(bus.char_ready_o), 1);
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] col);
    bus.char_data_i  = c;
    bus.colr_i       = col;
    bus.char_valid_i = 1'b1;
    wait_rdy();
    @(negedge clk);
    bus.char_valid_i = 1'b0;
    wait_rdy();
  endtask

  task automatic scan_clear(input logic [7:0] col,
                            output int uniq, output int bad);
    bit seen [4096];
    uniq = 0;
    bad  = 0;
    foreach (wlog[i]) begin
      logic [11:0] a;
      a = wlog[i][27:16];
      if (a[6:0] >= 7'd80 || a[11:7] >= 5'd25 ||
          wlog[i][15:8] != 8'h20 || wlog[i][7:0] != col)
        bad++;
      if (!seen[a]) begin
        seen[a] = 1'b1;
        uniq++;
      end
    end
  endtask

  initial begin
    int uniq, bad, nacc, gapbad, busyacc, last;
    bus.char_valid_i  = 1'b0;
    bus.char_data_i   = 8'h00;
    bus.colr_i        = 8'h00;
    bus1.char_valid_i = 1'b0;
    bus1.char_data_i  = 8'h00;
    bus1.colr_i       = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(bus.char_ready_o), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_wren",  32'({bus.wren_ms_o, bus.wren_mc_o}), 0);
    chk("rst_addr",  32'(bus.wr_addr_o), 0);
    chk("rst_data",  32'({bus.wr_char_o, bus.wr_colr_o}), 0);
    chk("rst_cur",   32'({cy, cx}), 0);
    chk("rst_ready_nc", 32'(bus1.char_ready_o), 0);

    rst_n = 1'b1;
    wlog.delete();
    @(negedge clk);
    chk("nc_ready_1st", 32'(bus1.char_ready_o), 1);
    chk("clr_busy", 32'(busy), 1);
    chk("clr_ready_lo", 32'(bus.char_ready_o), 0);
    wait_rdy();
    chk("clr_count", wlog.size(), 2000);
    scan_clear(8'h07, uniq, bad);
    chk("clr_unique", uniq, 2000);
    chk("clr_bad", bad, 0);
    chk("clr_cur", 32'({cy, cx}), 0);
    chk("clr_busy_end", 32'(busy), 0);

    wlog.delete();
    send(8'h41, 8'h1F);
    chk("a_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("a_write", 32'(wlog[0]), 32'h000_41_1F);
    chk("a_cur", 32'({cy, cx}), {5'd0, 7'd1});

    repeat (24) send(8'h0A, 8'h00);
    repeat (79) send(8'h78, 8'h05);
    chk("pre_wrap_cur", 32'({cy, cx}), {5'd24, 7'd79});
    wlog.delete();
    send(8'h42, 8'h33);
    chk("wrap_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("wrap_write", 32'(wlog[0]), 32'hC4F_42_33);
    chk("wrap_cur", 32'({cy, cx}), 0);

    repeat (3) send(8'h0A, 8'h00);
    repeat (5) send(8'h2E, 8'h01);
    chk("pre_bs_cur", 32'({cy, cx}), {5'd3, 7'd5});
    wlog.delete();
    send(8'h08, 8'h2A);
    chk("bs_count", wlog.size(), 1);
    if (wlog.size() > 0) chk("bs_write", 32'(wlog[0]), 32'h184_20_2A);
    chk("bs_cur", 32'({cy, cx}), {5'd3, 7'd4});
    wlog.delete();
    send(8'h0D, 8'h00);
    chk("cr_cur", 32'({cy, cx}), {5'd3, 7'd0});
    send(8'h0A, 8'h00);
    chk("crlf_cur", 32'({cy, cx}), {5'd4, 7'd0});
    send(8'h08, 8'h00);
    chk("bs0_cur", 32'({cy, cx}), {5'd4, 7'd0});
    chk("ctrl_nowrite", wlog.size(), 0);

    wlog.delete();
    nacc = 0;
    gapbad = 0;
    busyacc = 0;
    last = -2;
    bus.char_data_i  = 8'h61;
    bus.colr_i       = 8'h0E;
    bus.char_valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.char_ready_o) begin
        if (busy) busyacc++;
        if (i - last != 2) gapbad++;
        last = i;
        nacc++;
      end
      @(negedge clk);
    end
    bus.char_valid_i = 1'b0;
    wait_rdy();
    chk("thr_accepts", nacc, 6);
    chk("thr_gap", gapbad, 0);
    chk("thr_busyacc", busyacc, 0);
    chk("thr_writes", wlog.size(), 6);
    chk("thr_cur", 32'({cy, cx}), {5'd4, 7'd6});

    wlog.delete();
    bus.char_data_i  = 8'h0C;
    bus.colr_i       = 8'h4B;
    bus.char_valid_i = 1'b1;
    @(negedge clk);
    bus.char_valid_i = 1'b0;
    begin
      int n = 0;
      while (wlog.size() < 100 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("ff_100", wlog.size(), 100);
    scan_clear(8'h4B, uniq, bad);
    chk("ff_data", bad, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_wren", 32'({bus.wren_ms_o, bus.wren_mc_o}), 0);
    chk("abort_cur", 32'({cy, cx}), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("abort_nowr", wlog.size(), 100);
    rst_n = 1'b1;
    wlog.delete();
    @(negedge clk);
    wait_rdy();
    chk("reclr_count", wlog.size(), 2000);
    chk("en_match", en_mis, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
